// File: rtl/audio_recorder.sv
// Left-channel I2S capture from the WM8731 ADC into consecutive SRAM words.
// Single clock domain on the codec bit clock; every output comes straight from a register.
module audio_recorder #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_BCLK,
    input  logic              i_rst_n,
    input  logic              i_record,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_ADCLRCK,
    input  logic              i_ADCDAT,
    output logic              o_SRAM_WE_N,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [DATA_W-1:0] o_SRAM_DQ,
    output logic [ADDR_W-1:0] o_len,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLrc,
        StDelay,
        StRecv,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              lrck_q;
    logic              rec_q;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              we_n_q;
    logic              busy_q;
    logic              done_q;

    logic left_edge;
    logic rec_rise;

    assign left_edge = lrck_q & ~i_ADCLRCK;
    assign rec_rise  = i_record & ~rec_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        dq_d     = dq_q;
        addr_d   = addr_q;
        len_d    = len_q;
        unique case (state_q)
            StIdle: begin
                addr_d = i_start_addr;
                if (rec_rise) begin
                    len_d   = '0;
                    state_d = StWaitLrc;
                end
            end
            StWaitLrc: begin
                // Stop outranks pause; pause only gates the start of a new frame.
                if (i_stop) begin
                    state_d = StDone;
                end else if (left_edge && !i_pause) begin
                    state_d = StDelay;
                end
            end
            StDelay: begin
                bitcnt_d = '0;
                state_d  = i_stop ? StDone : StRecv;
            end
            StRecv: begin
                if (i_stop) begin
                    state_d = StDone;
                end else begin
                    shreg_d  = {shreg_q[DATA_W-2:0], i_ADCDAT};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                        dq_d    = shreg_d;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                len_d = len_q + ADDR_W'(1);
                if (addr_q == MAX_ADDR || i_stop) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StWaitLrc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            lrck_q   <= 1'b1;
            rec_q    <= 1'b0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            dq_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            we_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lrck_q   <= i_ADCLRCK;
            rec_q    <= i_record;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            dq_q     <= dq_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            we_n_q   <= (state_d != StWrite);
            busy_q   <= (state_d != StIdle);
            done_q   <= (state_q == StDone);
        end
    end

    assign o_SRAM_WE_N = we_n_q;
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_DQ   = dq_q;
    assign o_len       = len_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: random I2S frames against a frame-level model of what
// should land in SRAM for each recording session.
module tb_audio_recorder;

    localparam logic [19:0] MAX = 20'h00FFF;

    logic        clk;
    logic        rst_n;
    logic        record;
    logic        pause;
    logic        stop;
    logic [19:0] start_addr;
    logic        lrck;
    logic        dat;
    logic        we_n;
    logic [19:0] addr;
    logic [15:0] dq;
    logic [19:0] len;
    logic        busy;
    logic        done;

    audio_recorder #(
        .DATA_W  (16),
        .ADDR_W  (20),
        .MAX_ADDR(MAX)
    ) dut (
        .i_BCLK      (clk),
        .i_rst_n     (rst_n),
        .i_record    (record),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_start_addr(start_addr),
        .i_ADCLRCK   (lrck),
        .i_ADCDAT    (dat),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_ADDR (addr),
        .o_SRAM_DQ   (dq),
        .o_len       (len),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed SRAM traffic and done pulses.
    logic [19:0] got_addr[$];
    logic [15:0] got_data[$];
    int          long_pulse = 0;
    bit          we_prev_low = 0;
    int          done_cnt = 0;
    logic [19:0] done_len;
    logic [19:0] done_addr;

    // Session model: which words should be written where.
    logic [19:0] exp_addr[$];
    logic [15:0] exp_data[$];
    bit          m_active;
    logic [19:0] m_addr;
    logic [19:0] m_len;
    int          done_base;

    always @(negedge clk) begin
        if (!we_n) begin
            got_addr.push_back(addr);
            got_data.push_back(dq);
            if (we_prev_low) long_pulse++;
        end
        we_prev_low = !we_n;
        if (done) begin
            done_cnt++;
            done_len  = len;
            done_addr = addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":we_n"}, we_n, 1);
        check({tag, ":addr"}, addr, 0);
        check({tag, ":dq"}, dq, 0);
        check({tag, ":len"}, len, 0);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
    endtask

    task automatic model_frame(input logic [15:0] s, input bit paused, input bit aborted);
        if (!m_active) return;
        if (aborted) begin
            m_active = 0;
            return;
        end
        if (paused) return;
        exp_addr.push_back(m_addr);
        exp_data.push_back(s);
        m_len++;
        if (m_addr == MAX) m_active = 0;
        else m_addr++;
    endtask

    // One 40-cycle LRCK frame: edge cycle, delay slot, 16 data bits MSB first, right slot random.
    task automatic frame(input logic [15:0] s, input logic dbit, input int stop_bit,
                         input int rst_bit);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lrck = (c >= 20);
            if (c == 1) dat = dbit;
            else if (c >= 2 && c < 18) dat = s[17-c];
            else dat = 1'($urandom_range(0, 1));
            if (stop_bit >= 0 && c == 2 + stop_bit) stop = 1'b1;
            if (stop_bit >= 0 && c == 5 + stop_bit) stop = 1'b0;
            if (rst_bit >= 0 && c == 2 + rst_bit) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("t6_async_rst");
            end
        end
        model_frame(s, pause, (stop_bit >= 0) || (rst_bit >= 0));
    endtask

    task automatic start_rec(input string tag, input logic [19:0] a);
        record = 1'b0;
        start_addr = a;
        repeat (2) @(negedge clk);
        record = 1'b1;
        repeat (3) @(negedge clk);
        m_active  = 1;
        m_addr    = a;
        m_len     = 0;
        done_base = done_cnt;
        check({tag, ":busy"}, busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == done_base && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":done_seen"}, 32'(done_cnt != done_base), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic end_session(input string tag);
        check({tag, ":nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s:addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s:data%0d", tag, i), got_data[i], exp_data[i]);
        end
        check({tag, ":we_pulse_1cyc"}, long_pulse, 0);
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
        long_pulse = 0;
    endtask

    task automatic finish_rec(input string tag, input bit with_pause);
        stop  = 1'b1;
        pause = with_pause;
        wait_done(tag);
        stop  = 1'b0;
        pause = 1'b0;
        check({tag, ":done_len"}, done_len, m_len);
        check({tag, ":done_once"}, done_cnt - done_base, 1);
        check({tag, ":busy_after"}, busy, 0);
        repeat (3) @(negedge clk);
        check({tag, ":len_hold"}, len, m_len);
        end_session(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] s;
        bit          p;
        rst_n      = 1'b0;
        record     = 1'b0;
        pause      = 1'b0;
        stop       = 1'b0;
        start_addr = 20'h0;
        lrck       = 1'b1;
        dat        = 1'b0;
        m_active   = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("t0_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three left frames written to consecutive words.
        start_rec("t1", 20'h100);
        frame(16'hA5C3, 1'b0, -1, -1);
        frame(16'h0001, 1'b1, -1, -1);
        frame(16'h8000, 1'b1, -1, -1);
        finish_rec("t1", 0);

        // Delay slot carries a 1 that must not leak into the word.
        start_rec("t2", 20'h200);
        frame(16'h0000, 1'b1, -1, -1);
        frame(16'($urandom), 1'b1, -1, -1);
        finish_rec("t2", 0);

        // Stop at bit 7 of the second frame discards it.
        start_rec("t3", 20'h300);
        frame(16'($urandom), 1'b0, -1, -1);
        frame(16'($urandom), 1'b0, 7, -1);
        wait_done("t3");
        check("t3:done_len", done_len, 1);
        check("t3:model_len", m_len, 1);
        end_session("t3");

        // Pause held across two frames.
        start_rec("t4", 20'h400);
        frame(16'($urandom), 1'b0, -1, -1);
        pause = 1'b1;
        frame(16'($urandom), 1'b0, -1, -1);
        frame(16'($urandom), 1'b0, -1, -1);
        pause = 1'b0;
        frame(16'($urandom), 1'b0, -1, -1);
        finish_rec("t4", 0);

        // Capacity: two words left before MAX, four frames offered, record kept high.
        start_rec("t5", MAX - 20'h1);
        for (int i = 0; i < 4; i++) frame(16'($urandom), 1'b0, -1, -1);
        check("t5:done_once", done_cnt - done_base, 1);
        check("t5:done_addr", done_addr, MAX);
        check("t5:done_len", done_len, 2);
        check("t5:busy", busy, 0);
        end_session("t5");

        // Reset in the middle of a sample.
        start_rec("t6", 20'h500);
        frame(16'($urandom), 1'b0, -1, 5);
        record = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6:busy_after", busy, 0);
        end_session("t6");

        // Random session with random pauses, ended by stop and pause together.
        for (int r = 0; r < 2; r++) begin
            start_rec("t7", 20'($urandom_range(0, 20'h0F00)));
            for (int i = 0; i < 5; i++) begin
                s = 16'($urandom);
                p = ($urandom_range(0, 2) == 0);
                pause = p;
                frame(s, 1'($urandom_range(0, 1)), -1, -1);
                pause = 1'b0;
            end
            finish_rec("t7", 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
